// File: rtl/y_mdu.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One bit per clock: shift-add multiply, restoring divide, start/busy/done handshake.
module y_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;    // product or quotient sign
  logic                 rneg_q, rneg_d;  // remainder sign
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic [2*WIDTH-1:0]   p_q, p_d;        // multiply: {acc, multiplier}; divide: {rem, dividend}
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     abs_a, abs_b, addend, div_rem, quo, rem;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic                 div_ok, accept;
  logic [2*WIDTH-1:0]   mul_next, div_next, step_next, prod;

  always_comb begin
    abs_a     = (op[0] && a[WIDTH-1]) ? -a : a;
    abs_b     = (op[0] && b[WIDTH-1]) ? -b : b;

    addend    = p_q[0] ? mag_q : '0;
    mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mul_next  = {mul_sum, p_q[WIDTH-1:1]};

    // Shift the next dividend bit into the partial remainder and try to subtract.
    div_trial = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]} - {1'b0, mag_q};
    div_ok    = ~div_trial[WIDTH];
    div_rem   = div_ok ? div_trial[WIDTH-1:0] : {p_q[2*WIDTH-2:WIDTH], p_q[WIDTH-1]};
    div_next  = {div_rem, p_q[WIDTH-2:0], div_ok};

    step_next = is_div_q ? div_next : mul_next;
    prod      = neg_q ? -step_next : step_next;
    quo       = neg_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
    rem       = rneg_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
  end

  assign accept = start && (state_q != StRun);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    mag_d    = mag_q;
    p_d      = p_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      StRun: begin
        p_d   = step_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFin;
          dbz_d   = 1'b0;
          if (is_div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      if (op[1] && (b == '0)) begin
        state_d = StFin;
        hi_d    = a;
        lo_d    = '1;
        dbz_d   = 1'b1;
      end else begin
        state_d  = StRun;
        cnt_d    = '0;
        is_div_d = op[1];
        neg_d    = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg_d   = op[0] & op[1] & a[WIDTH-1];
        mag_d    = op[1] ? abs_b : abs_a;
        p_d      = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      mag_q    <= '0;
      p_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      mag_q    <= mag_d;
      p_q      <= p_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StFin);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_y_mdu.sv
// Scoreboard bench for y_mdu: stimulus pushes expected hi/lo/div_by_zero,
// a monitor pops and compares on every done pulse.
module tb_y_mdu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  y_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no completion");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
      end
    end
  end

  task automatic push(input logic [W-1:0] h, input logic [W-1:0] l, input logic z,
                      input string name);
    exp_t e;
    e.hi = h; e.lo = l; e.dbz = z; e.name = name;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit hold);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int lat, input string name);
    int k = 0;
    @(negedge clk);
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done, expected done after %0d edges", name, lat);
    end else begin
      chk({name, "_latency"}, 64'(cyc - acc_cyc), 64'(lat));
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez,
                        input int lat, input string name);
    push(eh, el, ez, name);
    issue(o, x, y, 1'b0);
    if (lat > 0) chk({name, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat, name);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32, "multu_max");
    run_op(2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 32, "multu_shift");
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 32, "mult_neg");
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 32, "mult_minmin");
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32, "div_negdvd");
    run_op(2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 32, "div_negdvs");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 32, "div_ovf");
    run_op(2'b10, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0, "divu_zero");

    repeat (3) @(posedge clk);
    #1 chk("dbz_holds_idle", 64'(div_by_zero), 64'd1);

    // divu 50/7 with a second start mid-run that must be ignored.
    push(32'd1, 32'd7, 1'b0, "divu_ignore");
    issue(2'b10, 32'd50, 32'd7, 1'b0);
    chk("dbz_holds_busy", 64'(div_by_zero), 64'd1);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; a = 32'd1000; b = 32'd3; op = 2'b00;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(32, "divu_ignore");

    // Reset mid-run aborts the operation; no done pulse may follow.
    issue(2'b10, 32'd123, 32'd4, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    // Back-to-back: start held high, second op accepted in the FIN cycle.
    push(32'd0, 32'd42, 1'b0, "b2b_first");
    push(32'd0, 32'd6, 1'b0, "b2b_second");
    issue(2'b00, 32'd6, 32'd7, 1'b1);
    op = 2'b01; a = 32'hFFFF_FFFE; b = 32'hFFFF_FFFD;
    wait_done(32, "b2b_first");
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(32, "b2b_second");

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
